gray_ptr_rx: RTL and testbench



---
 rtl/gray_ptr_rx_if.sv | 35 +++
 rtl/gray_ptr_rx.sv | 118 +++++++++++
 tb/tb_gray_ptr_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gray_ptr_rx_if.sv
// rtl/gray_ptr_rx_if.sv - bundle between the Gray pointer source and the gray_ptr_rx receiver (GRAY_PTR_RX_STEP_CHECK_EN adds err/err_clr)
interface gray_ptr_rx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] gray_sync;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] delta;
    logic             upd;
    logic             ready;
`ifdef GRAY_PTR_RX_STEP_CHECK_EN
    logic             err;
    logic             err_clr;

    modport master (
        output gray_in, err_clr,
        input  gray_sync, bin_out, delta, upd, ready, err
    );

    modport slave (
        input  gray_in, err_clr,
        output gray_sync, bin_out, delta, upd, ready, err
    );
`else
    modport master (
        output gray_in,
        input  gray_sync, bin_out, delta, upd, ready
    );

    modport slave (
        input  gray_in,
        output gray_sync, bin_out, delta, upd, ready
    );
`endif
endinterface

// File: rtl/gray_ptr_rx.sv
// rtl/gray_ptr_rx.sv - Gray pointer synchroniser, binary converter and advance tracker (optional step check: GRAY_PTR_RX_STEP_CHECK_EN)
module gray_ptr_rx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_STEP    = 1
) (
    input  logic          clk,
    input  logic          rst,
    gray_ptr_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PRIME = 2'd1,
        TRACK = 2'd2
    } state_t;

    // Fill counter only needs to reach SYNC_STAGES-1 (at most 3).
    localparam logic [2:0] FILL_LAST = 3'(SYNC_STAGES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] gray_sync;
    logic [WIDTH-1:0] conv;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] delta_q;
    logic             upd_q;
    logic             ready_q;
    logic [2:0]       fill_cnt;
    state_t           state;

    // Plain flop chain: no logic between stages so metastability can settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign gray_sync = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of its Gray bit and all higher Gray bits.
    always_comb begin
        conv = '0;
        for (int i = 0; i < WIDTH; i++) begin
            conv[i] = ^(gray_sync >> i);
        end
    end

    // Sequencer: wait for the chain to fill, prime bin_out without a delta, then track.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            fill_cnt <= '0;
            bin_q    <= '0;
            delta_q  <= '0;
            upd_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (fill_cnt == FILL_LAST) begin
                        state <= PRIME;
                    end else begin
                        fill_cnt <= fill_cnt + 3'd1;
                    end
                end
                PRIME: begin
                    bin_q   <= conv;
                    delta_q <= '0;
                    upd_q   <= 1'b0;
                    ready_q <= 1'b0;
                    state   <= TRACK;
                end
                TRACK: begin
                    bin_q   <= conv;
                    delta_q <= conv - bin_q;
                    upd_q   <= (conv != bin_q);
                    ready_q <= 1'b1;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

`ifdef GRAY_PTR_RX_STEP_CHECK_EN
    localparam logic [WIDTH-1:0] STEP_LIMIT = WIDTH'(MAX_STEP);

    logic err_q;

    // Sticky step-violation flag; a new violation beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == TRACK && delta_q > STEP_LIMIT) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign bus.err = err_q;
`endif

    assign bus.gray_sync = gray_sync;
    assign bus.bin_out   = bin_q;
    assign bus.delta     = delta_q;
    assign bus.upd       = upd_q;
    assign bus.ready     = ready_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// tb/tb_gray_ptr_rx.sv - scoreboard bench for gray_ptr_rx (WIDTH=4, SYNC_STAGES=2, MAX_STEP=1)
module tb_gray_ptr_rx;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   prev_bin;
    logic [7:0] exp_q [$];

    gray_ptr_rx_if #(.WIDTH(4)) bus_if ();

    gray_ptr_rx #(
        .WIDTH       (4),
        .SYNC_STAGES (2),
        .MAX_STEP    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    // Issue one new count and push the expected {bin_out, delta} for the monitor.
    task automatic step_to(input int b);
        @(posedge clk);
        #1;
        bus_if.gray_in = gray(b);
        exp_q.push_back({4'(b), 4'((b - prev_bin) & 15)});
        prev_bin = b;
        repeat (3) @(posedge clk);
    endtask

    // Monitor: every upd pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus_if.upd === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_upd", 32'(bus_if.bin_out), 32'hFFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("sb_bin_out", 32'(bus_if.bin_out), 32'(e[7:4]));
                check("sb_delta", 32'(bus_if.delta), 32'(e[3:0]));
            end
        end
    end

    initial begin
        errors   = 0;
        checks   = 0;
        prev_bin = 0;
        rst      = 1'b1;
        bus_if.gray_in = 4'h5;
`ifdef GRAY_PTR_RX_STEP_CHECK_EN
        bus_if.err_clr = 1'b0;
`endif

        // Reset with gray_in = 5 (binary 6)
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gray_sync", 32'(bus_if.gray_sync), 32'h0);
        check("rst_bin_out", 32'(bus_if.bin_out), 32'h0);
        check("rst_delta", 32'(bus_if.delta), 32'h0);
        check("rst_upd", 32'(bus_if.upd), 32'h0);
        check("rst_ready", 32'(bus_if.ready), 32'h0);
`ifdef GRAY_PTR_RX_STEP_CHECK_EN
        check("rst_err", 32'(bus_if.err), 32'h0);
`endif
        rst = 1'b0;

        @(posedge clk);
        @(negedge clk);
        check("fill1_gray_sync", 32'(bus_if.gray_sync), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("fill2_gray_sync", 32'(bus_if.gray_sync), 32'h5);
        check("fill2_bin_out", 32'(bus_if.bin_out), 32'h0);
        check("fill2_ready", 32'(bus_if.ready), 32'h0);

        @(posedge clk);
        @(negedge clk);
        check("prime_bin_out", 32'(bus_if.bin_out), 32'h6);
        check("prime_delta", 32'(bus_if.delta), 32'h0);
        check("prime_upd", 32'(bus_if.upd), 32'h0);
        check("prime_ready", 32'(bus_if.ready), 32'h0);

        @(posedge clk);
        @(negedge clk);
        check("track_ready", 32'(bus_if.ready), 32'h1);
        check("track_upd", 32'(bus_if.upd), 32'h0);
        check("track_bin_out", 32'(bus_if.bin_out), 32'h6);
        prev_bin = 6;

        // 6 -> 0 is a 10-count advance
        step_to(0);
        // Walk 1..15 and wrap to 0, one count per step
        for (int i = 1; i <= 16; i++) begin
            step_to(i % 16);
        end
        @(negedge clk);
        check("wrap_bin_out", 32'(bus_if.bin_out), 32'h0);
`ifdef GRAY_PTR_RX_STEP_CHECK_EN
        check("err_sticky_after_walk", 32'(bus_if.err), 32'h1);
`endif

        step_to(1);
`ifdef GRAY_PTR_RX_STEP_CHECK_EN
        @(negedge clk);
        bus_if.err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.err_clr = 1'b0;
        check("err_clr_stable", 32'(bus_if.err), 32'h0);
`endif

        // Jump Gray 1 -> 7 (binary 1 -> 5)
        @(posedge clk);
        #1;
        bus_if.gray_in = 4'h7;
        exp_q.push_back({4'h5, 4'h4});
        prev_bin = 5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("jump_latency_bin", 32'(bus_if.bin_out), 32'h1);
        check("jump_latency_upd", 32'(bus_if.upd), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("jump_bin_out", 32'(bus_if.bin_out), 32'h5);
        check("jump_upd", 32'(bus_if.upd), 32'h1);
`ifdef GRAY_PTR_RX_STEP_CHECK_EN
        check("jump_err_not_yet", 32'(bus_if.err), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("jump_err_set", 32'(bus_if.err), 32'h1);
        bus_if.err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("err_clr_after_jump", 32'(bus_if.err), 32'h0);
        // err_clr held high across a new 5 -> 9 violation
`endif
        @(posedge clk);
        #1;
        bus_if.gray_in = 4'hD;
        exp_q.push_back({4'h9, 4'h4});
        prev_bin = 9;
        repeat (4) @(posedge clk);
        @(negedge clk);
`ifdef GRAY_PTR_RX_STEP_CHECK_EN
        check("err_set_beats_clr", 32'(bus_if.err), 32'h1);
        bus_if.err_clr = 1'b0;
`endif

        // Hold input constant for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_upd", 32'(bus_if.upd), 32'h0);
            check("hold_delta", 32'(bus_if.delta), 32'h0);
            check("hold_bin_out", 32'(bus_if.bin_out), 32'h9);
`ifdef GRAY_PTR_RX_STEP_CHECK_EN
            check("hold_err", 32'(bus_if.err), 32'h1);
`endif
        end

        // Move to binary 10 (Gray F), then reset mid-track
        step_to(10);
        @(negedge clk);
        check("pre_rst_bin_out", 32'(bus_if.bin_out), 32'hA);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_gray_sync", 32'(bus_if.gray_sync), 32'h0);
        check("midrst_bin_out", 32'(bus_if.bin_out), 32'h0);
        check("midrst_delta", 32'(bus_if.delta), 32'h0);
        check("midrst_upd", 32'(bus_if.upd), 32'h0);
        check("midrst_ready", 32'(bus_if.ready), 32'h0);
`ifdef GRAY_PTR_RX_STEP_CHECK_EN
        check("midrst_err", 32'(bus_if.err), 32'h0);
`endif
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reprime_bin_out", 32'(bus_if.bin_out), 32'hA);
        check("reprime_delta", 32'(bus_if.delta), 32'h0);
        check("reprime_ready", 32'(bus_if.ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("retrack_ready", 32'(bus_if.ready), 32'h1);
        check("retrack_upd", 32'(bus_if.upd), 32'h0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
